// File: rtl/interp_ctrl_pkg.sv
// Shared definitions for the Bayer interpolator controller: stream dtype codes,
// state encodings and the config shadow record. Optional stats: INTERP_CTRL_STATS_EN.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'h3
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'h4
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 4'h8
`endif

package interp_ctrl_pkg;

  localparam int DTW = `DTYPE_WIDTH;

  localparam logic [DTW-1:0] DT_FRAME_START = `DTYPE_FRAME_START;
  localparam logic [DTW-1:0] DT_FRAME_END   = `DTYPE_FRAME_END;
  localparam logic [DTW-1:0] DT_ROW_START   = `DTYPE_ROW_START;
  localparam logic [DTW-1:0] DT_ROW_END     = `DTYPE_ROW_END;
  localparam logic [DTW-1:0] DT_PIXEL_MASK  = `DTYPE_PIXEL_MASK;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FRAME = 2'd1;
  localparam logic [1:0] ROW   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_FRAME = FRAME,
    ST_ROW   = ROW
  } ctrl_state_e;

  typedef struct packed {
    logic       en;
    logic [1:0] phase;
  } cfg_t;

  // Mirror swaps the column phase, flip swaps the row phase.
  function automatic logic [1:0] eff_phase(input logic [1:0] phase,
                                           input logic flip,
                                           input logic mirror);
    return phase ^ {flip, mirror};
  endfunction

endpackage

// File: rtl/interp_ctrl_stats.sv
// Frame geometry counters, row-length consistency check and per-frame
// dimension/count reporting for interp_ctrl. Strobes arrive pre-qualified by state.
module interp_ctrl_stats
  import interp_ctrl_pkg::*;
#(
  parameter int NUM_COLS_WIDTH  = 11,
  parameter int NUM_ROWS_WIDTH  = 11,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       frame_start,
  input  logic                       row_start,
  input  logic                       pix,
  input  logic                       row_end,
  input  logic                       frame_end,
  input  logic                       err_clr,
  output logic                       err_geom,
  output logic [NUM_ROWS_WIDTH-1:0]  num_rows,
  output logic [NUM_COLS_WIDTH-1:0]  num_cols,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  logic [NUM_COLS_WIDTH-1:0]  col_cnt_q, col_cnt_d;
  logic [NUM_COLS_WIDTH-1:0]  ref_len_q, ref_len_d;
  logic [NUM_ROWS_WIDTH-1:0]  row_cnt_q, row_cnt_d;
  logic [NUM_ROWS_WIDTH-1:0]  num_rows_q, num_rows_d;
  logic [NUM_COLS_WIDTH-1:0]  num_cols_q, num_cols_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                       err_geom_q, err_geom_d;

  always_comb begin
    col_cnt_d     = col_cnt_q;
    ref_len_d     = ref_len_q;
    row_cnt_d     = row_cnt_q;
    num_rows_d    = num_rows_q;
    num_cols_d    = num_cols_q;
    frame_count_d = frame_count_q;
    err_geom_d    = err_geom_q & ~err_clr;

    if (frame_start) begin
      col_cnt_d = '0;
      row_cnt_d = '0;
      ref_len_d = '0;
    end else begin
      if (row_start) col_cnt_d = '0;
      if (pix && (col_cnt_q != '1)) col_cnt_d = col_cnt_q + NUM_COLS_WIDTH'(1);
      // The first row of a frame defines the reference length for the rest.
      if (row_end) begin
        if (row_cnt_q == '0) ref_len_d = col_cnt_q;
        else if (col_cnt_q != ref_len_q) err_geom_d = 1'b1;
        if (row_cnt_q != '1) row_cnt_d = row_cnt_q + NUM_ROWS_WIDTH'(1);
      end
      if (frame_end) begin
        num_rows_d    = row_cnt_q;
        num_cols_d    = ref_len_q;
        frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      col_cnt_q     <= '0;
      ref_len_q     <= '0;
      row_cnt_q     <= '0;
      num_rows_q    <= '0;
      num_cols_q    <= '0;
      frame_count_q <= '0;
      err_geom_q    <= 1'b0;
    end else begin
      col_cnt_q     <= col_cnt_d;
      ref_len_q     <= ref_len_d;
      row_cnt_q     <= row_cnt_d;
      num_rows_q    <= num_rows_d;
      num_cols_q    <= num_cols_d;
      frame_count_q <= frame_count_d;
      err_geom_q    <= err_geom_d;
    end
  end

  assign err_geom    = err_geom_q;
  assign num_rows    = num_rows_q;
  assign num_cols    = num_cols_q;
  assign frame_count = frame_count_q;

endmodule

// File: rtl/interp_ctrl.sv
// Frame-synchronous controller for the Bayer interpolator: protocol FSM,
// frame-aligned config commit, sticky errors. Stats built under INTERP_CTRL_STATS_EN.
module interp_ctrl
  import interp_ctrl_pkg::*;
#(
  parameter int NUM_COLS_WIDTH  = 11,
  parameter int NUM_ROWS_WIDTH  = 11,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       dvi,
  input  logic [`DTYPE_WIDTH-1:0]    dtypei,
  input  logic                       cfg_enable,
  input  logic [1:0]                 cfg_phase,
  input  logic                       cfg_mirror,
  input  logic                       cfg_flip,
  input  logic                       cfg_update,
  input  logic                       err_clr,
  output logic                       enable_o,
  output logic [1:0]                 phase_o,
  output logic                       pending,
  output logic                       cfg_applied,
  output logic                       in_frame,
  output logic                       err_proto,
  output logic                       err_geom,
  output logic [NUM_ROWS_WIDTH-1:0]  num_rows,
  output logic [NUM_COLS_WIDTH-1:0]  num_cols,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  ctrl_state_e state_q, state_d;
  cfg_t        live_q, live_d;
  cfg_t        shadow_q, shadow_d;
  cfg_t        cfg_in;
  logic        pending_q, pending_d;
  logic        applied_q, applied_d;
  logic        err_proto_q, err_proto_d;
  logic        proto_evt;

  logic is_pix, is_fs, is_fe, is_rs, is_re;

  // Pixel types carry the mask bit; control codes never do.
  assign is_pix = dvi && ((dtypei & `DTYPE_PIXEL_MASK) != '0);
  assign is_fs  = dvi && !is_pix && (dtypei == `DTYPE_FRAME_START);
  assign is_fe  = dvi && !is_pix && (dtypei == `DTYPE_FRAME_END);
  assign is_rs  = dvi && !is_pix && (dtypei == `DTYPE_ROW_START);
  assign is_re  = dvi && !is_pix && (dtypei == `DTYPE_ROW_END);

  always_comb begin
    state_d   = state_q;
    proto_evt = 1'b0;
    if (is_pix) begin
      if (state_q != ST_ROW) proto_evt = 1'b1;
    end else if (is_fs) begin
      // FRAME_START always resynchronises, even when it is itself an error.
      if (state_q != ST_IDLE) proto_evt = 1'b1;
      state_d = ST_FRAME;
    end else if (is_fe) begin
      case (state_q)
        ST_FRAME: state_d = ST_IDLE;
        ST_ROW: begin
          proto_evt = 1'b1;
          state_d   = ST_IDLE;
        end
        default: proto_evt = 1'b1;
      endcase
    end else if (is_rs) begin
      if (state_q == ST_FRAME) state_d = ST_ROW;
      else proto_evt = 1'b1;
    end else if (is_re) begin
      if (state_q == ST_ROW) state_d = ST_FRAME;
      else proto_evt = 1'b1;
    end
    err_proto_d = (err_proto_q & ~err_clr) | proto_evt;
  end

  always_comb begin
    cfg_in.en    = cfg_enable;
    cfg_in.phase = eff_phase(cfg_phase, cfg_flip, cfg_mirror);
    live_d       = live_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    applied_d    = 1'b0;
    if (is_fs && cfg_update) begin
      live_d    = cfg_in;
      shadow_d  = cfg_in;
      pending_d = 1'b0;
      applied_d = 1'b1;
    end else if (is_fs && pending_q) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
      applied_d = 1'b1;
    end else if (cfg_update) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      live_q      <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      applied_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= live_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      applied_q   <= applied_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign enable_o    = live_q.en;
  assign phase_o     = live_q.phase;
  assign pending     = pending_q;
  assign cfg_applied = applied_q;
  assign in_frame    = (state_q != ST_IDLE);
  assign err_proto   = err_proto_q;

`ifdef INTERP_CTRL_STATS_EN
  interp_ctrl_stats #(
    .NUM_COLS_WIDTH (NUM_COLS_WIDTH),
    .NUM_ROWS_WIDTH (NUM_ROWS_WIDTH),
    .FRAME_CNT_WIDTH(FRAME_CNT_WIDTH)
  ) u_stats (
    .clk        (clk),
    .resetb     (resetb),
    .frame_start(is_fs),
    .row_start  (is_rs && (state_q == ST_FRAME)),
    .pix        (is_pix && (state_q == ST_ROW)),
    .row_end    (is_re && (state_q == ST_ROW)),
    .frame_end  (is_fe && (state_q == ST_FRAME)),
    .err_clr    (err_clr),
    .err_geom   (err_geom),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .frame_count(frame_count)
  );
`else
  assign err_geom    = 1'b0;
  assign num_rows    = '0;
  assign num_cols    = '0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_interp_ctrl.sv
// Self-checking bench for interp_ctrl: directed scenarios followed by random
// frame traffic, all outputs compared every cycle against a beat-level model.
module tb_interp_ctrl;
  import interp_ctrl_pkg::*;

  logic            clk;
  logic            resetb;
  logic            dvi;
  logic [DTW-1:0]  dtypei;
  logic            cfg_enable;
  logic [1:0]      cfg_phase;
  logic            cfg_mirror;
  logic            cfg_flip;
  logic            cfg_update;
  logic            err_clr;
  logic            enable_o;
  logic [1:0]      phase_o;
  logic            pending;
  logic            cfg_applied;
  logic            in_frame;
  logic            err_proto;
  logic            err_geom;
  logic [10:0]     num_rows;
  logic [10:0]     num_cols;
  logic [15:0]     frame_count;

  interp_ctrl dut (
    .clk(clk), .resetb(resetb), .dvi(dvi), .dtypei(dtypei),
    .cfg_enable(cfg_enable), .cfg_phase(cfg_phase), .cfg_mirror(cfg_mirror),
    .cfg_flip(cfg_flip), .cfg_update(cfg_update), .err_clr(err_clr),
    .enable_o(enable_o), .phase_o(phase_o), .pending(pending),
    .cfg_applied(cfg_applied), .in_frame(in_frame), .err_proto(err_proto),
    .err_geom(err_geom), .num_rows(num_rows), .num_cols(num_cols),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit rnd_side = 1'b0;
  int frame_no = 0;

  // Reference model: stream position as booleans, finished row lengths in a queue.
  bit m_in_frame, m_in_row;
  int m_cols;
  int row_lens[$];
  bit m_err_p, m_err_g;
  int m_num_rows, m_num_cols, m_frames;
  bit m_en, m_pending, m_sh_en, m_applied;
  int m_ph, m_sh_ph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_in_row = 0; m_cols = 0; row_lens.delete();
    m_err_p = 0; m_err_g = 0; m_num_rows = 0; m_num_cols = 0; m_frames = 0;
    m_en = 0; m_ph = 0; m_pending = 0; m_sh_en = 0; m_sh_ph = 0; m_applied = 0;
  endtask

  task automatic model_edge();
    bit perr = 0, gerr = 0, fs = 0;
    if (dvi) begin
      if ((dtypei & DT_PIXEL_MASK) != 0) begin
        if (m_in_row) begin if (m_cols < 2047) m_cols++; end
        else perr = 1;
      end else if (dtypei == DT_FRAME_START) begin
        perr = m_in_frame;
        m_in_frame = 1; m_in_row = 0; m_cols = 0; row_lens.delete(); fs = 1;
      end else if (dtypei == DT_FRAME_END) begin
        if (!m_in_frame || m_in_row) perr = 1;
        else begin
          m_num_rows = row_lens.size();
          m_num_cols = (row_lens.size() > 0) ? row_lens[0] : 0;
          m_frames = (m_frames + 1) % 65536;
        end
        if (m_in_frame) begin m_in_frame = 0; m_in_row = 0; end
      end else if (dtypei == DT_ROW_START) begin
        if (m_in_frame && !m_in_row) begin m_in_row = 1; m_cols = 0; end
        else perr = 1;
      end else if (dtypei == DT_ROW_END) begin
        if (m_in_row) begin
          if (row_lens.size() > 0 && m_cols != row_lens[0]) gerr = 1;
          row_lens.push_back(m_cols);
          m_in_row = 0;
        end else perr = 1;
      end
    end
    m_err_p = perr || (m_err_p && !err_clr);
    m_err_g = gerr || (m_err_g && !err_clr);
    m_applied = 0;
    if (fs && cfg_update) begin
      m_en = cfg_enable; m_ph = cfg_phase ^ {cfg_flip, cfg_mirror};
      m_pending = 0; m_applied = 1;
    end else if (fs && m_pending) begin
      m_en = m_sh_en; m_ph = m_sh_ph; m_pending = 0; m_applied = 1;
    end else if (cfg_update) begin
      m_sh_en = cfg_enable; m_sh_ph = cfg_phase ^ {cfg_flip, cfg_mirror};
      m_pending = 1;
    end
  endtask

  task automatic compare_all();
    chk("enable_o", enable_o, m_en);
    chk("phase_o", phase_o, m_ph);
    chk("pending", pending, m_pending);
    chk("cfg_applied", cfg_applied, m_applied);
    chk("in_frame", in_frame, m_in_frame);
    chk("err_proto", err_proto, m_err_p);
`ifdef INTERP_CTRL_STATS_EN
    chk("err_geom", err_geom, m_err_g);
    chk("num_rows", num_rows, m_num_rows);
    chk("num_cols", num_cols, m_num_cols);
    chk("frame_count", frame_count, m_frames);
`else
    chk("err_geom", err_geom, 0);
    chk("num_rows", num_rows, 0);
    chk("num_cols", num_cols, 0);
    chk("frame_count", frame_count, 0);
`endif
  endtask

  // Present one beat for one clock, then check the model against the DUT.
  task automatic beat(input bit dv, input logic [DTW-1:0] dt);
    dvi = dv;
    dtypei = dv ? dt : DTW'($urandom_range(0, 15));
    if (rnd_side) begin
      cfg_update = ($urandom_range(0, 9) == 0);
      err_clr    = ($urandom_range(0, 19) == 0);
      cfg_enable = 1'($urandom_range(0, 1));
      cfg_phase  = 2'($urandom_range(0, 3));
      cfg_mirror = 1'($urandom_range(0, 1));
      cfg_flip   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    model_edge();
    compare_all();
    dvi = 0; cfg_update = 0; err_clr = 0;
  endtask

  function automatic logic [DTW-1:0] pix_code();
    return DT_PIXEL_MASK | DTW'($urandom_range(0, 7));
  endfunction

  task automatic send_row(input int n);
    beat(1, DT_ROW_START);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) beat(0, '0);
      if (rnd_side && $urandom_range(0, 29) == 0) beat(1, DTW'($urandom_range(0, 15)));
      beat(1, pix_code());
    end
    beat(1, DT_ROW_END);
  endtask

  task automatic send_rows(input int rows, input int cols);
    for (int r = 0; r < rows; r++) send_row(cols);
  endtask

  task automatic send_frame(input int rows, input int cols);
    beat(1, DT_FRAME_START);
    send_rows(rows, cols);
    beat(1, DT_FRAME_END);
    frame_no++;
    $display("frame %0d: %0dx%0d err_proto=%0b err_geom=%0b phase_o=%0d", frame_no, rows, cols,
             err_proto, err_geom, phase_o);
  endtask

  task automatic set_cfg(input bit en, input int ph, input bit mir, input bit flp);
    cfg_enable = en; cfg_phase = 2'(ph); cfg_mirror = mir; cfg_flip = flp;
  endtask

  initial begin
    resetb = 0; dvi = 0; dtypei = '0; cfg_update = 0; err_clr = 0;
    set_cfg(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) resetb = 1;
    #1 compare_all();

    // Staged config commits exactly at the next FRAME_START.
    set_cfg(1, 2, 1, 0); cfg_update = 1;
    beat(0, '0);
    chk("t1_pending", pending, 1);
    chk("t1_no_early", enable_o, 0);
    beat(1, DT_FRAME_START);
    chk("t1_enable", enable_o, 1);
    chk("t1_phase", phase_o, 3);
    chk("t1_applied", cfg_applied, 1);
    send_rows(4, 6);
    beat(1, DT_FRAME_END);
    chk("t1_applied_gone", cfg_applied, 0);

    // Update mid-row stays pending through the frame end.
    beat(1, DT_FRAME_START);
    beat(1, DT_ROW_START);
    beat(1, pix_code());
    set_cfg(1, 1, 0, 0); cfg_update = 1;
    beat(1, pix_code());
    beat(1, DT_ROW_END);
    beat(1, DT_FRAME_END);
    chk("t2_hold_phase", phase_o, 3);
    chk("t2_pending", pending, 1);
    beat(1, DT_FRAME_START);
    chk("t2_phase", phase_o, 1);
    send_rows(2, 3);
    beat(1, DT_FRAME_END);

    // Update on the FRAME_START beat commits directly.
    set_cfg(1, 0, 0, 1); cfg_update = 1;
    beat(1, DT_FRAME_START);
    chk("t3_phase", phase_o, 2);
    chk("t3_pending", pending, 0);
    send_rows(1, 2);
    beat(1, DT_FRAME_END);

    // Protocol errors and resync.
    beat(1, DT_FRAME_START);
    beat(1, pix_code());
    chk("t4_err_proto", err_proto, 1);
    beat(1, DT_ROW_START);
    beat(1, pix_code());
    beat(1, DT_FRAME_START);
    chk("t4_resync", in_frame, 1);
    send_rows(3, 5);
    beat(1, DT_FRAME_END);
`ifdef INTERP_CTRL_STATS_EN
    chk("t4_num_rows", num_rows, 3);
    chk("t4_num_cols", num_cols, 5);
`endif
    err_clr = 1;
    beat(0, '0);
    chk("t4_err_clr", err_proto, 0);

    // Row-length mismatch.
    beat(1, DT_FRAME_START);
    send_rows(2, 8);
    send_row(7);
`ifdef INTERP_CTRL_STATS_EN
    chk("t5_err_geom", err_geom, 1);
`endif
    beat(1, DT_FRAME_END);
    beat(1, DT_FRAME_START);
    send_row(8);
    beat(1, DT_ROW_START);
    for (int i = 0; i < 5; i++) beat(1, pix_code());
    err_clr = 1;
    beat(1, DT_ROW_END);
`ifdef INTERP_CTRL_STATS_EN
    chk("t5_geom_wins", err_geom, 1);
`endif
    beat(1, DT_FRAME_END);
    err_clr = 1;
    beat(0, '0);

    // Asynchronous reset mid-frame with a pending update.
    set_cfg(0, 3, 0, 0); cfg_update = 1;
    beat(0, '0);
    beat(1, DT_FRAME_START);
    set_cfg(1, 2, 1, 1); cfg_update = 1;
    beat(1, DT_ROW_START);
    beat(1, pix_code());
    #2 resetb = 0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk) resetb = 1;
    beat(1, DT_FRAME_START);
    chk("t6_no_commit", cfg_applied, 0);
    send_rows(2, 2);
    beat(1, DT_FRAME_END);

    // Random traffic.
    rnd_side = 1;
    for (int f = 0; f < 40; f++) begin
      int rows = $urandom_range(1, 4);
      int cols = $urandom_range(1, 6);
      repeat ($urandom_range(0, 3)) beat(0, '0);
      if ($urandom_range(0, 5) == 0) beat(1, DTW'($urandom_range(0, 15)));
      beat(1, DT_FRAME_START);
      for (int r = 0; r < rows; r++)
        send_row(($urandom_range(0, 6) == 0) ? cols + 1 : cols);
      beat(1, DT_FRAME_END);
      frame_no++;
      $display("frame %0d: random %0dx%0d err_proto=%0b err_geom=%0b phase_o=%0d",
               frame_no, rows, cols, err_proto, err_geom, phase_o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
